// File: rtl/mux_nx1_rr_if.sv
// Lane-side and serializer-side signals of the N:1 lane merger, grouped as one bus.
// master = lane staging + serializer side, slave = the merger itself.
interface mux_nx1_rr_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) ();
    logic                   enable;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       in_valid;
    logic [LANES-1:0]       in_ack;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic [LW-1:0]          out_lane;

    modport master (
        output enable,
        output in_data,
        output in_valid,
        input  in_ack,
        input  out_data,
        input  out_valid,
        input  out_lane
    );

    modport slave (
        input  enable,
        input  in_data,
        input  in_valid,
        output in_ack,
        output out_data,
        output out_valid,
        output out_lane
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// N:1 lane merger (TDM or skip-idle round-robin); 1-clock registered output latency.
// No downstream backpressure; lanes not acknowledged must hold their word until in_ack.
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int MODE  = 0
) (
    input  logic        clk,
    input  logic        reset_L,
    mux_nx1_rr_if.slave bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [LW-1:0]    out_lane_q, out_lane_d;

    logic             cand_vld;
    logic [LW-1:0]    cand_idx;
    logic             gnt;
    logic [WIDTH-1:0] gnt_data;

    // Modulo-LANES add; base and ofs are both below LANES so one subtract suffices.
    function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int ofs);
        logic [LW:0] sum;
        sum = {1'b0, base} + (LW+1)'(ofs);
        if (sum >= (LW+1)'(LANES)) begin
            sum = sum - (LW+1)'(LANES);
        end
        return sum[LW-1:0];
    endfunction

    generate
        if (MODE == 0) begin : g_tdm
            always_comb begin
                cand_vld = bus.in_valid[ptr_q];
                cand_idx = ptr_q;
            end
        end else begin : g_rr
            // Scan from the far end so the lane closest to ptr wins last.
            always_comb begin
                cand_vld = 1'b0;
                cand_idx = ptr_q;
                for (int j = LANES - 1; j >= 0; j--) begin
                    if (bus.in_valid[wrap_add(ptr_q, j)]) begin
                        cand_vld = 1'b1;
                        cand_idx = wrap_add(ptr_q, j);
                    end
                end
            end
        end
    endgenerate

    // Gating with reset_L drops any word offered while reset is asserted.
    assign gnt      = cand_vld & bus.enable & reset_L;
    assign gnt_data = bus.in_data[int'(cand_idx)*WIDTH +: WIDTH];

    always_comb begin
        bus.in_ack = '0;
        if (gnt) begin
            bus.in_ack[cand_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (bus.enable) begin
            if (MODE == 0) begin
                ptr_d = wrap_add(ptr_q, 1);
            end else if (gnt) begin
                ptr_d = wrap_add(cand_idx, 1);
            end
        end
    end

    always_comb begin
        out_valid_d = gnt;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        if (gnt) begin
            out_data_d = gnt_data;
            out_lane_d = cand_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lane  = out_lane_q;
endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: four parameter variants driven side by side, checked against
// a lane-scan reference model every cycle plus hand-computed literal points.
module tb_mux_nx1_rr;
    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    // Variants: 0 TDM L4 W8, 1 RR L3 W8, 2 RR L5 W16, 3 TDM L5 W16
    int lanes_m[4] = '{4, 3, 5, 5};
    int mode_m[4]  = '{0, 1, 1, 0};
    int wid_m[4]   = '{8, 8, 16, 16};

    logic        en_s[4];
    logic [4:0]  vld_s[4];
    logic [15:0] dat_s[4][5];

    logic [4:0]  a_ack[4];
    logic [15:0] a_dat[4];
    logic        a_vld[4];
    logic [2:0]  a_lane[4];

    int          m_ptr[4]  = '{0, 0, 0, 0};
    logic        m_vld[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] m_dat[4]  = '{16'h0, 16'h0, 16'h0, 16'h0};
    int          m_lane[4] = '{0, 0, 0, 0};

    int n_checks = 0;
    int n_errors = 0;

    mux_nx1_rr_if #(.WIDTH(8),  .LANES(4)) if0 ();
    mux_nx1_rr_if #(.WIDTH(8),  .LANES(3)) if1 ();
    mux_nx1_rr_if #(.WIDTH(16), .LANES(5)) if2 ();
    mux_nx1_rr_if #(.WIDTH(16), .LANES(5)) if3 ();

    mux_nx1_rr #(.WIDTH(8),  .LANES(4), .MODE(0)) u0 (.clk(clk), .reset_L(reset_L), .bus(if0));
    mux_nx1_rr #(.WIDTH(8),  .LANES(3), .MODE(1)) u1 (.clk(clk), .reset_L(reset_L), .bus(if1));
    mux_nx1_rr #(.WIDTH(16), .LANES(5), .MODE(1)) u2 (.clk(clk), .reset_L(reset_L), .bus(if2));
    mux_nx1_rr #(.WIDTH(16), .LANES(5), .MODE(0)) u3 (.clk(clk), .reset_L(reset_L), .bus(if3));

    assign if0.enable = en_s[0];
    assign if1.enable = en_s[1];
    assign if2.enable = en_s[2];
    assign if3.enable = en_s[3];
    assign if0.in_valid = vld_s[0][3:0];
    assign if1.in_valid = vld_s[1][2:0];
    assign if2.in_valid = vld_s[2];
    assign if3.in_valid = vld_s[3];

    always_comb begin
        if0.in_data = '0;
        for (int l = 0; l < 4; l++) if0.in_data[l*8 +: 8] = dat_s[0][l][7:0];
    end
    always_comb begin
        if1.in_data = '0;
        for (int l = 0; l < 3; l++) if1.in_data[l*8 +: 8] = dat_s[1][l][7:0];
    end
    always_comb begin
        if2.in_data = '0;
        for (int l = 0; l < 5; l++) if2.in_data[l*16 +: 16] = dat_s[2][l];
    end
    always_comb begin
        if3.in_data = '0;
        for (int l = 0; l < 5; l++) if3.in_data[l*16 +: 16] = dat_s[3][l];
    end

    assign a_ack[0]  = {1'b0, if0.in_ack};
    assign a_ack[1]  = {2'b0, if1.in_ack};
    assign a_ack[2]  = if2.in_ack;
    assign a_ack[3]  = if3.in_ack;
    assign a_dat[0]  = {8'h00, if0.out_data};
    assign a_dat[1]  = {8'h00, if1.out_data};
    assign a_dat[2]  = if2.out_data;
    assign a_dat[3]  = if3.out_data;
    assign a_vld[0]  = if0.out_valid;
    assign a_vld[1]  = if1.out_valid;
    assign a_vld[2]  = if2.out_valid;
    assign a_vld[3]  = if3.out_valid;
    assign a_lane[0] = {1'b0, if0.out_lane};
    assign a_lane[1] = {1'b0, if1.out_lane};
    assign a_lane[2] = if2.out_lane;
    assign a_lane[3] = if3.out_lane;

    // Granted lane under the current inputs, or -1 when nothing is taken.
    function automatic int mgrant(int k);
        if (!reset_L || !en_s[k]) return -1;
        if (mode_m[k] == 0) return vld_s[k][m_ptr[k]] ? m_ptr[k] : -1;
        for (int j = 0; j < lanes_m[k]; j++) begin
            int l = (m_ptr[k] + j) % lanes_m[k];
            if (vld_s[k][l]) return l;
        end
        return -1;
    endfunction

    function automatic logic [4:0] expack(int k);
        int g = mgrant(k);
        return (g >= 0) ? (5'd1 << g) : 5'd0;
    endfunction

    function automatic logic [15:0] mdata(int k, int g);
        return (wid_m[k] == 8) ? {8'h00, dat_s[k][g][7:0]} : dat_s[k][g];
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 4; k++) begin
                m_ptr[k]  <= 0;
                m_vld[k]  <= 1'b0;
                m_dat[k]  <= 16'h0;
                m_lane[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                m_vld[k] <= (mgrant(k) >= 0);
                if (mgrant(k) >= 0) begin
                    m_dat[k]  <= mdata(k, mgrant(k));
                    m_lane[k] <= mgrant(k);
                end
                if (en_s[k]) begin
                    if (mode_m[k] == 0) m_ptr[k] <= (m_ptr[k] + 1) % lanes_m[k];
                    else if (mgrant(k) >= 0) m_ptr[k] <= (mgrant(k) + 1) % lanes_m[k];
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("in_ack", k, 32'(a_ack[k]), 32'(expack(k)));
            chk("out_valid", k, 32'(a_vld[k]), 32'(m_vld[k]));
            chk("out_data", k, 32'(a_dat[k]), 32'(m_dat[k]));
            chk("out_lane", k, 32'(a_lane[k]), 32'(m_lane[k]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_vld"}, k, 32'(a_vld[k]), 32'd0);
            chk({tag, "_dat"}, k, 32'(a_dat[k]), 32'd0);
            chk({tag, "_lane"}, k, 32'(a_lane[k]), 32'd0);
            chk({tag, "_ack"}, k, 32'(a_ack[k]), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] seq_a[5];
        int         seq_rr3[5];
        int         pulses;
        seq_a   = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        seq_rr3 = '{0, 1, 2, 0, 1};

        reset_L = 1'b0;
        for (int k = 0; k < 4; k++) begin
            en_s[k]  = 1'b1;
            vld_s[k] = 5'b11111;
        end
        for (int l = 0; l < 5; l++) begin
            dat_s[0][l] = 16'h00A0 + 16'(l);
            dat_s[1][l] = 16'h00A0 + 16'(l);
            dat_s[2][l] = 16'hC000 + 16'(l);
            dat_s[3][l] = 16'hBEE0 + 16'(l);
        end
        tick;
        tick;
        all_zero("rst");

        reset_L = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) chk("first_ack", k, 32'(a_ack[k]), 32'd1);

        // All lanes valid: TDM and RR both walk the lanes in order.
        for (int c = 0; c < 5; c++) begin
            tick;
            chk("tdm4_seq", 0, 32'(a_dat[0]), 32'(seq_a[c]));
            chk("rr3_seq", 1, 32'(a_lane[1]), 32'(seq_rr3[c]));
            chk("tdm5_lane", 3, 32'(a_lane[3]), 32'(c));
            chk("tdm5_vld", 3, 32'(a_vld[3]), 32'd1);
        end

        // Sparse lanes: TDM slot for lane 2 only, RR alternation, RR 4->0 wrap.
        vld_s[0] = 5'b00100;
        dat_s[0][2] = 16'h005C;
        vld_s[1] = 5'b00101;
        dat_s[1][0] = 16'h0010;
        dat_s[1][2] = 16'h0012;
        vld_s[2] = 5'b10001;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (a_vld[0]) pulses++;
            chk("rr3_alt_lane", 1, 32'(a_lane[1]), (c % 2 == 0) ? 32'd2 : 32'd0);
            chk("rr3_alt_vld", 1, 32'(a_vld[1]), 32'd1);
            chk("rr5_wrap_lane", 2, 32'(a_lane[2]), (c % 2 == 0) ? 32'd0 : 32'd4);
        end
        chk("tdm4_pulses", 0, 32'(pulses), 32'd2);
        chk("tdm4_hold", 0, 32'(a_dat[0]), 32'h5C);

        // Freeze for three clocks.
        for (int k = 0; k < 4; k++) en_s[k] = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk("frz_ack", k, 32'(a_ack[k]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick;
            for (int k = 0; k < 4; k++) chk("frz_vld", k, 32'(a_vld[k]), 32'd0);
        end
        chk("frz_hold", 0, 32'(a_dat[0]), 32'h5C);
        for (int k = 0; k < 4; k++) en_s[k] = 1'b1;
        tick;
        chk("resume_lane", 3, 32'(a_lane[3]), 32'd3);
        chk("resume_dat", 3, 32'(a_dat[3]), 32'hBEE3);
        chk("resume_idle", 0, 32'(a_vld[0]), 32'd0);
        tick;
        chk("resume_slot", 0, 32'(a_vld[0]), 32'd1);
        chk("resume_slot_lane", 0, 32'(a_lane[0]), 32'd2);
        chk("resume_next", 3, 32'(a_lane[3]), 32'd4);

        // Asynchronous reset between edges while streaming.
        for (int k = 0; k < 4; k++) vld_s[k] = 5'b11111;
        for (int l = 0; l < 4; l++) dat_s[0][l] = 16'h00A0 + 16'(l);
        tick;
        chk("pre_arst_vld", 3, 32'(a_vld[3]), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        all_zero("arst");
        tick;
        tick;
        all_zero("arst_hold");
        reset_L = 1'b1;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("post_arst_lane", k, 32'(a_lane[k]), 32'd0);
            chk("post_arst_vld", k, 32'(a_vld[k]), 32'd1);
        end
        chk("post_arst_dat", 0, 32'(a_dat[0]), 32'hA0);
        chk("post_arst_dat", 3, 32'(a_dat[3]), 32'hBEE0);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
